// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer.
// Holds the default word width, its word type and the bit-counter width helper.
package sipo_pkg;

    localparam int DEF_WIDTH = 8;

    typedef logic [DEF_WIDTH-1:0] word_t;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// One-entry valid/ready holding register for completed deserializer words.
// A load into a full register that is not being drained is refused and flagged on drop.
module sipo_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             drop
);

    assign drop = load && out_valid && !out_ready;

    // A simultaneous drain and load keeps out_valid high so words flow without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load && (!out_valid || out_ready)) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deser8.sv
// Serial-in/parallel-out deserializer feeding the 8-bit register stage.
// Assembles WIDTH bits per word and reports words lost to a stalled consumer.
module sipo_deser8
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_en,
    input  logic             sync_clr,
    input  logic             out_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             drop;

    // The completed word goes straight to the holding register, never through sh.
    assign word      = MSB_FIRST ? {sh[WIDTH-2:0], ser_in} : {ser_in, sh[WIDTH-1:1]};
    assign word_done = ser_en && !sync_clr && !rst && (bit_cnt == LAST);
    assign busy      = (bit_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst || sync_clr) begin
            bit_cnt <= '0;
            sh      <= '0;
        end else if (ser_en) begin
            if (bit_cnt == LAST) begin
                bit_cnt <= '0;
                sh      <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                sh      <= word;
            end
        end
    end

    // A fresh drop beats a same-cycle clear so no lost word goes unreported.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    sipo_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (word_done),
        .load_data(word),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .drop     (drop)
    );

endmodule

// File: tb/tb_sipo_deser8.sv
// Directed bench for sipo_deser8: an MSB-first and an LSB-first instance share stimulus.
// A table covers the basic word flows; hand sequences cover overrun, stalls, sync_clr and reset.
module tb_sipo_deser8;
    import sipo_pkg::*;

    typedef struct {
        logic  rst;
        logic  ser_en;
        logic  ser_in;
        logic  out_ready;
        logic  exp_valid;
        word_t exp_msb;
        word_t exp_lsb;
        logic  exp_busy;
        logic  exp_ovr;
    } vec_t;

    logic  clk;
    logic  rst, ser_in, ser_en, sync_clr, out_ready, ovr_clr;
    word_t data_m, data_l;
    logic  valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;

    int    n_vec;
    int    n_err;
    vec_t  vecs[19];

    sipo_deser8 #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .ser_in(ser_in), .ser_en(ser_en), .sync_clr(sync_clr),
        .out_ready(out_ready), .ovr_clr(ovr_clr), .out_data(data_m), .out_valid(valid_m),
        .busy(busy_m), .overrun(ovr_m)
    );

    sipo_deser8 #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .ser_in(ser_in), .ser_en(ser_en), .sync_clr(sync_clr),
        .out_ready(out_ready), .ovr_clr(ovr_clr), .out_data(data_l), .out_valid(valid_l),
        .busy(busy_l), .overrun(ovr_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic r, input logic en, input logic b, input logic rdy,
                                input logic v, input word_t em, input word_t el,
                                input logic bz, input logic ov);
        vec_t t;
        t.rst = r; t.ser_en = en; t.ser_in = b; t.out_ready = rdy;
        t.exp_valid = v; t.exp_msb = em; t.exp_lsb = el; t.exp_busy = bz; t.exp_ovr = ov;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input word_t em,
                               input word_t el, input logic eb, input logic eo);
        n_vec++;
        if (valid_m !== ev || valid_l !== ev || data_m !== em || data_l !== el ||
            busy_m !== eb || busy_l !== eb || ovr_m !== eo || ovr_l !== eo) begin
            n_err++;
            $display("[TB] FAIL %s: got valid=%b/%b data=%h/%h busy=%b/%b ovr=%b/%b, expected valid=%b data=%h/%h busy=%b ovr=%b",
                     name, valid_m, valid_l, data_m, data_l, busy_m, busy_l, ovr_m, ovr_l,
                     ev, em, el, eb, eo);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst       = v.rst;
        ser_en    = v.ser_en;
        ser_in    = v.ser_in;
        out_ready = v.out_ready;
        tick();
    endtask

    // Sends the top n bits of v, most significant first, then idles ser_en.
    task automatic sendBits(input word_t v, input int n);
        for (int i = 0; i < n; i++) begin
            ser_in = v[7-i];
            ser_en = 1'b1;
            tick();
        end
        ser_en = 1'b0;
    endtask

    initial begin
        word_t pat;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; ser_in = 1'b0; ser_en = 1'b0; sync_clr = 1'b0;
        out_ready = 1'b1; ovr_clr = 1'b0;

        vecs[0] = mk(1, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++)
            vecs[1+i] = mk(0, 1, pat[7-i], 1, (i == 7),
                           (i == 7) ? 8'hA5 : 8'h00, (i == 7) ? 8'hA5 : 8'h00, (i != 7), 0);
        vecs[9] = mk(0, 0, 0, 1, 0, 8'hA5, 8'hA5, 0, 0);
        pat = 8'hC0;
        for (int i = 0; i < 8; i++)
            vecs[10+i] = mk(0, 1, pat[7-i], 1, (i == 7),
                            (i == 7) ? 8'hC0 : 8'hA5, (i == 7) ? 8'h03 : 8'hA5, (i != 7), 0);
        vecs[18] = mk(0, 0, 0, 1, 0, 8'hC0, 8'h03, 0, 0);

        tick();
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("table[%0d]", i), vecs[i].exp_valid, vecs[i].exp_msb,
                        vecs[i].exp_lsb, vecs[i].exp_busy, vecs[i].exp_ovr);
        end
        rst = 1'b0;

        // Overrun: second word dropped while the first is held
        out_ready = 1'b0;
        sendBits(8'h3C, 8);
        checkOutput("ovr_first_word", 1, 8'h3C, 8'h3C, 0, 0);
        sendBits(8'hC3, 7);
        checkOutput("ovr_bit15", 1, 8'h3C, 8'h3C, 1, 0);
        sendBits(8'h80, 1);
        checkOutput("ovr_bit16", 1, 8'h3C, 8'h3C, 0, 1);
        out_ready = 1'b1;
        tick();
        checkOutput("ovr_drain", 0, 8'h3C, 8'h3C, 0, 1);
        out_ready = 1'b0;
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        checkOutput("ovr_clear", 0, 8'h3C, 8'h3C, 0, 0);

        // Set beats clear on the same edge
        sendBits(8'h0F, 8);
        checkOutput("setwins_hold", 1, 8'h0F, 8'hF0, 0, 0);
        sendBits(8'hAA, 7);
        ovr_clr = 1'b1;
        sendBits(8'h00, 1);
        ovr_clr = 1'b0;
        checkOutput("setwins", 1, 8'h0F, 8'hF0, 0, 1);
        out_ready = 1'b1;
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        checkOutput("setwins_clear", 0, 8'h0F, 8'hF0, 0, 0);

        // Back-to-back: load and drain on the same edge, with ser_en gaps
        out_ready = 1'b0;
        sendBits(8'h11, 8);
        checkOutput("b2b_first", 1, 8'h11, 8'h88, 0, 0);
        sendBits(8'h22, 4);
        tick();
        tick();
        checkOutput("b2b_gap", 1, 8'h11, 8'h88, 1, 0);
        sendBits(8'h20, 3);
        out_ready = 1'b1;
        sendBits(8'h00, 1);
        checkOutput("b2b_second", 1, 8'h22, 8'h44, 0, 0);
        tick();
        checkOutput("b2b_drain", 0, 8'h22, 8'h44, 0, 0);

        // sync_clr mid-word leaves the held word alone and drops its own bit
        out_ready = 1'b0;
        sendBits(8'h96, 8);
        sendBits(8'hE0, 3);
        checkOutput("sclr_partial", 1, 8'h96, 8'h69, 1, 0);
        sync_clr = 1'b1;
        sendBits(8'h80, 1);
        sync_clr = 1'b0;
        checkOutput("sclr_applied", 1, 8'h96, 8'h69, 0, 0);
        out_ready = 1'b1;
        tick();
        checkOutput("sclr_drain", 0, 8'h96, 8'h69, 0, 0);
        sendBits(8'hF0, 8);
        checkOutput("sclr_next_word", 1, 8'hF0, 8'h0F, 0, 0);
        tick();

        // Reset with a held word, a pending overrun and a partial word
        out_ready = 1'b0;
        sendBits(8'h5A, 8);
        sendBits(8'hFF, 8);
        sendBits(8'hA0, 4);
        checkOutput("rst_before", 1, 8'h5A, 8'h5A, 1, 1);
        rst = 1'b1;
        sendBits(8'h80, 1);
        rst = 1'b0;
        checkOutput("rst_applied", 0, 8'h00, 8'h00, 0, 0);
        out_ready = 1'b1;
        sendBits(8'h81, 8);
        checkOutput("rst_fresh_word", 1, 8'h81, 8'h81, 0, 0);
        tick();
        checkOutput("rst_fresh_drain", 0, 8'h81, 8'h81, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
